// File: rtl/cory_loopnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cory_loopnd_pkg
// Description : Shared state encoding for the N-dimensional valid-ready loop.
// Revision    : 1.0 - initial release
// ============================================================================
package cory_loopnd_pkg;

    // Controller states: waiting for a command, or streaming beats of one.
    typedef enum logic [0:0] {
        CORY_LOOPND_IDLE = 1'b0,
        CORY_LOOPND_RUN  = 1'b1
    } state_t;

    // Upper bound on the number of loop dimensions the top accepts.
    localparam int c_MAX_DIMS = 8;

endpackage
`default_nettype wire

// File: rtl/cory_loopnd_dim.sv
`default_nettype none
// ============================================================================
// Module      : cory_loopnd_dim
// Description : One loop dimension: index counter, last-compare and the
//               row-base address register that inner dimensions restart from.
// Revision    : 1.0 - initial release
// ============================================================================
module cory_loopnd_dim #(
    parameter int W = 8,
    parameter int A = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clear,
    input  logic [A-1:0] i_base,
    input  logic [W-1:0] i_cnt,
    input  logic         i_step,
    input  logic         i_carry,
    input  logic [A-1:0] i_new_base,
    output logic         o_carry,
    output logic         o_last,
    output logic [W-1:0] o_idx,
    output logic [A-1:0] o_row_base
);

    logic [W-1:0] r_idx;
    logic [A-1:0] r_row_base;
    logic         w_last;

    // Last beat of this dimension when the index reaches count-1.
    assign w_last     = (r_idx == (i_cnt - W'(1)));
    // Carry out only when every inner dimension and this one are on their last.
    assign o_carry    = i_carry & w_last;
    assign o_last     = w_last;
    assign o_idx      = r_idx;
    assign o_row_base = r_row_base;

    // Index and row base: load on a new command, advance when inner dims wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx      <= '0;
            r_row_base <= '0;
        end else if (i_clear) begin
            r_idx      <= '0;
            r_row_base <= i_base;
        end else if (i_step && i_carry) begin
            // Either this is the dimension that increments, or it wraps to 0;
            // in both cases it restarts from the freshly computed address.
            r_idx      <= w_last ? '0 : (r_idx + W'(1));
            r_row_base <= i_new_base;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cory_loopnd.sv
`default_nettype none
// ============================================================================
// Module      : cory_loopnd
// Description : Repeats each accepted command over D nested dimensions, one
//               output beat per input beat, tagging beats with indices, last
//               flags and a strided address.
// Revision    : 1.0 - initial release
// ============================================================================
module cory_loopnd
    import cory_loopnd_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8,
    parameter int D = 3,
    parameter int A = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           i_cmd_v,
    input  logic [D*W-1:0] i_cmd_cnt,
    input  logic [A-1:0]   i_cmd_base,
    input  logic [D*A-1:0] i_cmd_stride,
    output logic           o_cmd_r,
    input  logic           i_a_v,
    input  logic [N-1:0]   i_a_d,
    output logic           o_a_r,
    output logic           o_z_v,
    output logic [N-1:0]   o_z_d,
    output logic [A-1:0]   o_z_addr,
    output logic [D*W-1:0] o_z_cnt,
    output logic [D-1:0]   o_z_last,
    output logic           o_z_end,
    input  logic           i_z_r
);

    state_t         r_state;
    state_t         w_next;
    logic [D*W-1:0] r_cnt;
    logic [D*A-1:0] r_stride;
    logic [A-1:0]   r_addr;

    logic           w_beat;
    logic           w_load;
    logic           w_cnt_zero;
    logic [D:0]     w_carry;
    logic [D-1:0]   w_last;
    logic [A-1:0]   w_row_base [D];
    logic [A-1:0]   w_sel_base;
    logic [A-1:0]   w_sel_stride;
    logic [A-1:0]   w_new_addr;
    logic           w_found;

    // Dimension 0 always sees a carry; each outer dim sees the inner wrap.
    assign w_carry[0] = 1'b1;

    generate
        for (genvar g = 0; g < D; g++) begin : g_dim
            cory_loopnd_dim #(
                .W (W),
                .A (A)
            ) u_dim (
                .clk        (clk),
                .reset_n    (reset_n),
                .i_clear    (w_load),
                .i_base     (i_cmd_base),
                .i_cnt      (r_cnt[g*W +: W]),
                .i_step     (w_beat),
                .i_carry    (w_carry[g]),
                .i_new_base (w_new_addr),
                .o_carry    (w_carry[g+1]),
                .o_last     (w_last[g]),
                .o_idx      (o_z_cnt[g*W +: W]),
                .o_row_base (w_row_base[g])
            );
        end
    endgenerate

    assign o_z_d    = i_a_d;
    assign o_z_addr = r_addr;
    assign o_z_last = w_last;
    assign o_z_end  = w_carry[D];

    // Pick row base and stride of the lowest dimension not yet on its last
    // index; with every dim on last the choice is irrelevant (command ends).
    always_comb begin
        w_sel_base   = w_row_base[0];
        w_sel_stride = r_stride[0 +: A];
        w_found      = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (!w_found && !w_last[k]) begin
                w_sel_base   = w_row_base[k];
                w_sel_stride = r_stride[k*A +: A];
                w_found      = 1'b1;
            end
        end
    end

    assign w_new_addr = w_sel_base + w_sel_stride;

    // A command with any zero count produces no beats and is dropped.
    always_comb begin
        w_cnt_zero = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (i_cmd_cnt[k*W +: W] == '0) begin
                w_cnt_zero = 1'b1;
            end
        end
    end

    // Next state and handshakes; a command may be taken on the final beat.
    always_comb begin
        w_next  = r_state;
        o_cmd_r = 1'b0;
        o_z_v   = 1'b0;
        o_a_r   = 1'b0;
        w_beat  = 1'b0;
        w_load  = 1'b0;
        case (r_state)
            CORY_LOOPND_IDLE: begin
                o_cmd_r = 1'b1;
                if (i_cmd_v && !w_cnt_zero) begin
                    w_load = 1'b1;
                    w_next = CORY_LOOPND_RUN;
                end
            end
            CORY_LOOPND_RUN: begin
                o_z_v  = i_a_v;
                o_a_r  = i_z_r;
                w_beat = i_a_v & i_z_r;
                if (w_beat && o_z_end) begin
                    o_cmd_r = 1'b1;
                    if (i_cmd_v && !w_cnt_zero) begin
                        w_load = 1'b1;
                    end else begin
                        w_next = CORY_LOOPND_IDLE;
                    end
                end
            end
            default: w_next = CORY_LOOPND_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= CORY_LOOPND_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latched command fields and running address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stride <= '0;
            r_addr   <= '0;
        end else if (w_load) begin
            r_cnt    <= i_cmd_cnt;
            r_stride <= i_cmd_stride;
            r_addr   <= i_cmd_base;
        end else if (w_beat) begin
            r_addr   <= w_new_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cory_loopnd.sv
`default_nettype none
// ============================================================================
// Module      : tb_cory_loopnd
// Description : Directed self-checking bench for cory_loopnd (D=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cory_loopnd;

    localparam int N = 8;
    localparam int W = 8;
    localparam int D = 3;
    localparam int A = 16;

    logic           clk;
    logic           reset_n;
    logic           cmd_v;
    logic [D*W-1:0] cmd_cnt;
    logic [A-1:0]   cmd_base;
    logic [D*A-1:0] cmd_stride;
    logic           cmd_r;
    logic           a_v;
    logic [N-1:0]   a_d;
    logic           a_r;
    logic           z_v;
    logic [N-1:0]   z_d;
    logic [A-1:0]   z_addr;
    logic [D*W-1:0] z_cnt;
    logic [D-1:0]   z_last;
    logic           z_end;
    logic           z_r;

    int n_checks = 0;
    int n_errors = 0;

    // Command presented back-to-back while the current one runs.
    logic [D*W-1:0] nxt_cnt;
    logic [A-1:0]   nxt_base;
    logic [D*A-1:0] nxt_stride;

    cory_loopnd #(.N(N), .W(W), .D(D), .A(A)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_cmd_v      (cmd_v),
        .i_cmd_cnt    (cmd_cnt),
        .i_cmd_base   (cmd_base),
        .i_cmd_stride (cmd_stride),
        .o_cmd_r      (cmd_r),
        .i_a_v        (a_v),
        .i_a_d        (a_d),
        .o_a_r        (a_r),
        .o_z_v        (z_v),
        .o_z_d        (z_d),
        .o_z_addr     (z_addr),
        .o_z_cnt      (z_cnt),
        .o_z_last     (z_last),
        .o_z_end      (z_end),
        .i_z_r        (z_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command while IDLE and let it be accepted on the next edge.
    task automatic issue_cmd(input logic [7:0] c0, c1, c2,
                             input logic [15:0] base, s0, s1, s2);
        @(negedge clk);
        cmd_cnt    = {c2, c1, c0};
        cmd_base   = base;
        cmd_stride = {s2, s1, s0};
        cmd_v      = 1'b1;
        a_v        = 1'b0;
        z_r        = 1'b0;
        #1;
        check("idle_cmd_r", 32'(cmd_r), 32'd1);
        check("idle_z_v", 32'(z_v), 32'd0);
        @(posedge clk);
    endtask

    // Walk the expected beat sequence of one command; stop early after
    // 'limit' beats when limit is non-zero.
    task automatic run_beats(input logic [7:0] c0, c1, c2,
                             input logic [15:0] base, s0, s1, s2,
                             input bit stall, input bit chain, input int limit);
        int b;
        logic [15:0] ea;
        logic [2:0]  el;
        logic        ee;
        logic [23:0] ec;
        b = 0;
        for (int i2 = 0; i2 < int'(c2); i2++) begin
            for (int i1 = 0; i1 < int'(c1); i1++) begin
                for (int i0 = 0; i0 < int'(c0); i0++) begin
                    if (limit != 0 && b == limit) return;
                    ea = base + s0 * 16'(i0) + s1 * 16'(i1) + s2 * 16'(i2);
                    el = {i2 == int'(c2) - 1, i1 == int'(c1) - 1, i0 == int'(c0) - 1};
                    ee = &el;
                    ec = {8'(i2), 8'(i1), 8'(i0)};
                    for (int t = 0; t < 64; t++) begin
                        @(negedge clk);
                        if (chain) begin
                            cmd_v      = 1'b1;
                            cmd_cnt    = nxt_cnt;
                            cmd_base   = nxt_base;
                            cmd_stride = nxt_stride;
                        end else begin
                            cmd_v = 1'b0;
                        end
                        if (stall && t < 63) begin
                            a_v = 1'($urandom_range(0, 1));
                            z_r = 1'($urandom_range(0, 1));
                        end else begin
                            a_v = 1'b1;
                            z_r = 1'b1;
                        end
                        a_d = 8'($urandom);
                        #1;
                        check("z_v", 32'(z_v), 32'(a_v));
                        check("a_r", 32'(a_r), 32'(z_r));
                        check("z_addr", 32'(z_addr), 32'(ea));
                        check("z_cnt", 32'(z_cnt), 32'(ec));
                        check("z_last", 32'(z_last), 32'(el));
                        check("z_end", 32'(z_end), 32'(ee));
                        check("cmd_r", 32'(cmd_r), 32'(a_v & z_r & ee));
                        if (a_v) check("z_d", 32'(z_d), 32'(a_d));
                        if (a_v && z_r) break;
                    end
                    @(posedge clk);
                    b++;
                end
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        cmd_v      = 1'b0;
        cmd_cnt    = '0;
        cmd_base   = '0;
        cmd_stride = '0;
        a_v        = 1'b0;
        a_d        = '0;
        z_r        = 1'b0;
        nxt_cnt    = '0;
        nxt_base   = '0;
        nxt_stride = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        a_v     = 1'b1;
        z_r     = 1'b1;
        #1;
        check("rst_cmd_r", 32'(cmd_r), 32'd1);
        check("rst_z_v", 32'(z_v), 32'd0);
        check("rst_a_r", 32'(a_r), 32'd0);
        check("rst_addr", 32'(z_addr), 32'd0);
        check("rst_cnt", 32'(z_cnt), 32'd0);

        // Basic 3-D walk, no stalls: 12 beats 0x100..0x221.
        issue_cmd(8'd2, 8'd3, 8'd2, 16'h0100, 16'h0001, 16'h0010, 16'h0100);
        run_beats(8'd2, 8'd3, 8'd2, 16'h0100, 16'h0001, 16'h0010, 16'h0100, 1'b0, 1'b0, 0);

        // Same command with random stalls.
        issue_cmd(8'd2, 8'd3, 8'd2, 16'h0100, 16'h0001, 16'h0010, 16'h0100);
        run_beats(8'd2, 8'd3, 8'd2, 16'h0100, 16'h0001, 16'h0010, 16'h0100, 1'b1, 1'b0, 0);

        // Back-to-back: second command held on i_cmd_v throughout the first.
        nxt_cnt    = {8'd1, 8'd2, 8'd2};
        nxt_base   = 16'h0800;
        nxt_stride = {16'h0000, 16'h0100, 16'h0004};
        issue_cmd(8'd3, 8'd1, 8'd1, 16'h0010, 16'h0002, 16'h0000, 16'h0000);
        run_beats(8'd3, 8'd1, 8'd1, 16'h0010, 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
        run_beats(8'd2, 8'd2, 8'd1, 16'h0800, 16'h0004, 16'h0100, 16'h0000, 1'b0, 1'b0, 0);

        // Zero count in dimension 1: dropped, stays IDLE.
        issue_cmd(8'd4, 8'd0, 8'd1, 16'h0300, 16'h0001, 16'h0001, 16'h0001);
        repeat (2) begin
            @(negedge clk);
            cmd_v = 1'b0;
            a_v   = 1'b1;
            z_r   = 1'b1;
            #1;
            check("zero_cmd_r", 32'(cmd_r), 32'd1);
            check("zero_z_v", 32'(z_v), 32'd0);
            check("zero_a_r", 32'(a_r), 32'd0);
        end
        issue_cmd(8'd2, 8'd2, 8'd1, 16'h0040, 16'h0004, 16'h0020, 16'h0000);
        run_beats(8'd2, 8'd2, 8'd1, 16'h0040, 16'h0004, 16'h0020, 16'h0000, 1'b0, 1'b0, 0);

        // Negative stride with wrap below zero.
        issue_cmd(8'd3, 8'd1, 8'd1, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000);
        run_beats(8'd3, 8'd1, 8'd1, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);

        // All-ones count in dimension 0 with a single outer iteration.
        issue_cmd(8'd255, 8'd1, 8'd1, 16'hFF00, 16'h0001, 16'h0000, 16'h0000);
        run_beats(8'd255, 8'd1, 8'd1, 16'hFF00, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);

        // Reset while beat 5 of 12 is presented.
        issue_cmd(8'd2, 8'd3, 8'd2, 16'h0100, 16'h0001, 16'h0010, 16'h0100);
        run_beats(8'd2, 8'd3, 8'd2, 16'h0100, 16'h0001, 16'h0010, 16'h0100, 1'b0, 1'b0, 4);
        @(negedge clk);
        reset_n = 1'b0;
        a_v     = 1'b1;
        z_r     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rst_z_v", 32'(z_v), 32'd0);
        check("mid_rst_cmd_r", 32'(cmd_r), 32'd1);
        check("mid_rst_cnt", 32'(z_cnt), 32'd0);
        issue_cmd(8'd2, 8'd3, 8'd2, 16'h0100, 16'h0001, 16'h0010, 16'h0100);
        run_beats(8'd2, 8'd3, 8'd2, 16'h0100, 16'h0001, 16'h0010, 16'h0100, 1'b0, 1'b0, 0);

        @(negedge clk);
        cmd_v = 1'b0;
        #1;
        check("end_idle_z_v", 32'(z_v), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
